// File: rtl/qr_pkg.sv
// qr_pkg: shared types and helpers for the QR module sampler.
//   state_t          - sampler FSM states
//   max_code()       - largest code side (modules) for a given max version
//   version_to_size  - code side length 17+4*version
//   SUB_READS        - frame reads per module (3 when QR_SAMPLER_MAJORITY_EN
//                      is defined, otherwise 1)
package qr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned ADDR_W  = 20;

`ifdef QR_SAMPLER_MAJORITY_EN
    localparam int unsigned SUB_READS = 3;
`else
    localparam int unsigned SUB_READS = 1;
`endif

    function automatic int max_code(input int max_version);
        return 17 + 4 * max_version;
    endfunction

    function automatic logic [5:0] version_to_size(input logic [2:0] version);
        return 6'd17 + {1'b0, version, 2'b00};
    endfunction

endpackage

// File: rtl/qr_addr_gen.sv
// qr_addr_gen: maps a module coordinate to a frame-buffer pixel address.
//   clk, rst_n     - clock, async active-low reset
//   valid_in       - a read is being issued this cycle
//   ox, oy         - sampling anchor (12-bit signed)
//   dx             - horizontal sub-read offset
//   x, y, ms       - module coordinate and module pitch
//   idx_in/last_in - bit index and last-sub-read tag carried alongside
//   address        - registered read address (0 when out of frame)
//   valid, in_frame, last, idx - registered tags aligned with address
module qr_addr_gen
    import qr_pkg::*;
#(
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 320,
    parameter int IDX_W  = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic signed [COORD_W-1:0] ox,
    input  logic signed [COORD_W-1:0] oy,
    input  logic signed [COORD_W-1:0] dx,
    input  logic [5:0]                x,
    input  logic [5:0]                y,
    input  logic [8:0]                ms,
    input  logic [IDX_W-1:0]          idx_in,
    input  logic                      last_in,
    output logic [ADDR_W-1:0]         address,
    output logic                      valid,
    output logic                      in_frame,
    output logic                      last,
    output logic [IDX_W-1:0]          idx
);

    logic signed [COORD_W-1:0] px;
    logic signed [COORD_W-1:0] py;
    logic                      in_bounds;
    logic [ADDR_W-1:0]         lin_addr;

    always_comb begin
        px        = ox - $signed({6'b0, x}) * $signed({3'b0, ms}) + dx;
        py        = oy - $signed({6'b0, y}) * $signed({3'b0, ms});
        in_bounds = (px >= 0) && (int'(px) < WIDTH) &&
                    (py >= 0) && (int'(py) < HEIGHT);
        lin_addr  = ADDR_W'(px) + ADDR_W'(py) * ADDR_W'(WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address  <= '0;
            valid    <= 1'b0;
            in_frame <= 1'b0;
            last     <= 1'b0;
            idx      <= '0;
        end else begin
            valid    <= valid_in;
            in_frame <= valid_in && in_bounds;
            last     <= last_in;
            idx      <= idx_in;
            address  <= (valid_in && in_bounds) ? lin_addr : '0;
        end
    end

endmodule

// File: rtl/qr_sampler.sv
// qr_sampler: samples a QR code grid from a thresholded frame buffer.
//   clk_in, rst_n_in     - clock, async active-low reset
//   start_in, version_in - request and QR version (1..MAX_VERSION)
//   module_size          - module pitch in pixels
//   centers_x/centers_y  - finder centres; index 2 is the sampling anchor
//   reading_pixel        - pixel returned READ_LATENCY cycles after address
//   reading_address      - frame buffer read address
//   qr_code, code_size   - sampled bits and code side length
//   busy, valid_qr       - activity flag and completion pulse
//   error_oof, error_ver - out-of-frame read seen / illegal version
// Build option: QR_SAMPLER_MAJORITY_EN selects 3 reads per module with a
// 2-of-3 majority vote instead of one centre read.
module qr_sampler
    import qr_pkg::*;
#(
    parameter  int WIDTH        = 480,
    parameter  int HEIGHT       = 320,
    parameter  int MAX_VERSION  = 4,
    parameter  int READ_LATENCY = 2,
    localparam int MAX_CODE     = max_code(MAX_VERSION),
    localparam int CODE_BITS    = MAX_CODE * MAX_CODE
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic [2:0]             version_in,
    input  logic [8:0]             module_size,
    input  logic [2:0][8:0]        centers_x,
    input  logic [2:0][8:0]        centers_y,
    input  logic                   reading_pixel,
    output logic [ADDR_W-1:0]      reading_address,
    output logic [CODE_BITS-1:0]   qr_code,
    output logic [5:0]             code_size,
    output logic                   busy,
    output logic                   valid_qr,
    output logic                   error_oof,
    output logic                   error_ver
);

    localparam int IDX_W = $clog2(CODE_BITS);

    state_t                    state;
    logic [5:0]                col;
    logic [5:0]                row;
    logic [1:0]                sub;
    logic [IDX_W-1:0]          idx;
    logic signed [COORD_W-1:0] ox;
    logic signed [COORD_W-1:0] oy;
    logic [8:0]                ms;
    logic [2:0]                drain_cnt;
    logic                      reject;

    logic                      issue;
    logic                      sub_last;
    logic signed [COORD_W-1:0] dx;
    logic                      version_ok;
    logic [5:0]                size_next;
    logic [IDX_W-1:0]          idx_first;
    logic                      sample;
    logic                      bit_val;

    logic                      ag_valid;
    logic                      ag_in_frame;
    logic                      ag_last;
    logic [IDX_W-1:0]          ag_idx;

    logic                      p_valid    [READ_LATENCY];
    logic                      p_in_frame [READ_LATENCY];
    logic                      p_last     [READ_LATENCY];
    logic [IDX_W-1:0]          p_idx      [READ_LATENCY];

    // Only the anchor finder (index 2) drives sampling.
    logic unused_centers;
    assign unused_centers = ^{centers_x[1:0], centers_y[1:0]};

`ifdef QR_SAMPLER_MAJORITY_EN
    logic [1:0]          ones;
    logic [1:0]          ones_next;
    logic [COORD_W-1:0]  quarter;
`endif

    always_comb begin
        issue      = (state == ISSUE);
        version_ok = (version_in != 3'd0) && (int'(version_in) <= MAX_VERSION);
        size_next  = version_to_size(version_in);
        idx_first  = IDX_W'(size_next) * IDX_W'(size_next) - IDX_W'(1);
        sub_last   = (32'(sub) == SUB_READS - 1);
        sample     = p_in_frame[READ_LATENCY-1] & reading_pixel;
`ifdef QR_SAMPLER_MAJORITY_EN
        quarter    = {5'b0, ms[8:2]};
        dx         = (sub == 2'd0) ? -quarter :
                     (sub == 2'd2) ?  quarter : '0;
        ones_next  = ones + {1'b0, sample};
        bit_val    = ones_next[1];
`else
        dx         = '0;
        bit_val    = sample;
`endif
    end

    qr_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .valid_in (issue),
        .ox       (ox),
        .oy       (oy),
        .dx       (dx),
        .x        (col),
        .y        (row),
        .ms       (ms),
        .idx_in   (idx),
        .last_in  (sub_last),
        .address  (reading_address),
        .valid    (ag_valid),
        .in_frame (ag_in_frame),
        .last     (ag_last),
        .idx      (ag_idx)
    );

    // Tags wait here for the frame buffer so they meet reading_pixel.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                p_valid[k]    <= 1'b0;
                p_in_frame[k] <= 1'b0;
                p_last[k]     <= 1'b0;
                p_idx[k]      <= '0;
            end
        end else begin
            p_valid[0]    <= ag_valid;
            p_in_frame[0] <= ag_in_frame;
            p_last[0]     <= ag_last;
            p_idx[0]      <= ag_idx;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                p_valid[k]    <= p_valid[k-1];
                p_in_frame[k] <= p_in_frame[k-1];
                p_last[k]     <= p_last[k-1];
                p_idx[k]      <= p_idx[k-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            sub       <= '0;
            idx       <= '0;
            ox        <= '0;
            oy        <= '0;
            ms        <= '0;
            drain_cnt <= '0;
            reject    <= 1'b0;
            qr_code   <= '0;
            code_size <= '0;
            busy      <= 1'b0;
            valid_qr  <= 1'b0;
            error_oof <= 1'b0;
            error_ver <= 1'b0;
`ifdef QR_SAMPLER_MAJORITY_EN
            ones      <= '0;
`endif
        end else begin
            valid_qr <= 1'b0;

            if (ag_valid && !ag_in_frame) begin
                error_oof <= 1'b1;
            end

            if (p_valid[READ_LATENCY-1]) begin
`ifdef QR_SAMPLER_MAJORITY_EN
                ones <= p_last[READ_LATENCY-1] ? '0 : ones_next;
`endif
                if (p_last[READ_LATENCY-1]) begin
                    qr_code[p_idx[READ_LATENCY-1]] <= bit_val;
                end
            end

            case (state)
                IDLE: begin
                    if (start_in) begin
                        if (version_ok) begin
                            ox        <= {3'b0, centers_x[2]} + 12'd3 * {3'b0, module_size};
                            oy        <= {3'b0, centers_y[2]} + 12'd3 * {3'b0, module_size};
                            ms        <= module_size;
                            code_size <= size_next;
                            col       <= '0;
                            row       <= '0;
                            sub       <= '0;
                            // Raster order visits bit indices from the top
                            // down, so the index is a plain down-counter.
                            idx       <= idx_first;
                            qr_code   <= '0;
                            busy      <= 1'b1;
                            error_oof <= 1'b0;
                            error_ver <= 1'b0;
                            state     <= ISSUE;
                        end else begin
                            error_ver <= 1'b1;
                            reject    <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (sub_last) begin
                        sub <= '0;
                        idx <= idx - IDX_W'(1);
                        if (col == code_size - 6'd1) begin
                            col <= '0;
                            if (row == code_size - 6'd1) begin
                                row       <= '0;
                                drain_cnt <= '0;
                                state     <= DRAIN;
                            end else begin
                                row <= row + 6'd1;
                            end
                        end else begin
                            col <= col + 6'd1;
                        end
                    end else begin
                        sub <= sub + 2'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'(READ_LATENCY - 1)) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                DONE: begin
                    valid_qr <= !reject;
                    busy     <= 1'b0;
                    reject   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_sampler.sv
// tb_qr_sampler: randomized self-checking bench for qr_sampler with a
// frame-buffer model and a behavioural sampling reference.
module tb_qr_sampler;

    localparam int W    = 480;
    localparam int H    = 320;
    localparam int RL   = 2;
    localparam int MAXV = 4;
    localparam int CB   = 33 * 33;
`ifdef QR_SAMPLER_MAJORITY_EN
    localparam int NS = 3;
`else
    localparam int NS = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_in;
    logic [2:0]     version_in;
    logic [8:0]     module_size;
    logic [2:0][8:0] centers_x;
    logic [2:0][8:0] centers_y;
    logic           reading_pixel;
    logic [19:0]    reading_address;
    logic [CB-1:0]  qr_code;
    logic [5:0]     code_size;
    logic           busy, valid_qr, error_oof, error_ver;

    always #5 clk = ~clk;

    qr_sampler #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .MAX_VERSION  (MAXV),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start_in),
        .version_in      (version_in),
        .module_size     (module_size),
        .centers_x       (centers_x),
        .centers_y       (centers_y),
        .reading_pixel   (reading_pixel),
        .reading_address (reading_address),
        .qr_code         (qr_code),
        .code_size       (code_size),
        .busy            (busy),
        .valid_qr        (valid_qr),
        .error_oof       (error_oof),
        .error_ver       (error_ver)
    );

    // Frame buffer: image plus an RL-deep read pipe.
    bit img [W*H];
    bit rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= (reading_address < W*H) ? img[reading_address] : 1'b0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign reading_pixel = rd_pipe[RL-1];

    int valid_cnt = 0;
    int addr_bad  = 0;
    always @(negedge clk) begin
        if (valid_qr) valid_cnt++;
        if (reading_address >= W*H) addr_bad++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: sample the image from the geometric rules directly.
    task automatic model_code(input int v, input int cx, input int cy, input int ms,
                              output logic [CB-1:0] code, output bit oof);
        int cs, ox, oy, px, py, ones;
        int offs[3];
        cs = 17 + 4*v;
        ox = cx + 3*ms;
        oy = cy + 3*ms;
        code = '0;
        oof = 1'b0;
        offs[0] = (NS == 3) ? -(ms/4) : 0;
        offs[1] = 0;
        offs[2] = ms/4;
        for (int y = 0; y < cs; y++) begin
            for (int x = 0; x < cs; x++) begin
                ones = 0;
                py = oy - y*ms;
                for (int s = 0; s < NS; s++) begin
                    px = ox - x*ms + offs[s];
                    if (px < 0 || px >= W || py < 0 || py >= H) oof = 1'b1;
                    else ones += int'(img[px + py*W]);
                end
                code[(cs-1-x) + (cs-1-y)*cs] = (NS == 3) ? (ones >= 2) : (ones == 1);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_code"},  $countones(qr_code), 0);
        check({tag, "_addr"},  reading_address, 0);
        check({tag, "_size"},  code_size, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_valid"}, valid_qr, 0);
        check({tag, "_oof"},   error_oof, 0);
        check({tag, "_ver"},   error_ver, 0);
    endtask

    task automatic apply_start(input int v, input int cx, input int cy, input int ms);
        @(negedge clk);
        version_in   = 3'(v);
        module_size  = 9'(ms);
        centers_x    = {9'(cx), 9'($urandom), 9'($urandom)};
        centers_y    = {9'(cy), 9'($urandom), 9'($urandom)};
        start_in     = 1'b1;
        @(negedge clk);
        start_in     = 1'b0;
        // Scramble inputs: the request must already be latched.
        version_in   = 3'($urandom);
        module_size  = 9'($urandom);
        centers_x    = {9'($urandom), 9'($urandom), 9'($urandom)};
        centers_y    = {9'($urandom), 9'($urandom), 9'($urandom)};
    endtask

    task automatic run_req(input int v, input int cx, input int cy, input int ms,
                           input string tag);
        logic [CB-1:0] exp;
        bit  exp_oof;
        int  cs, exp_lat, lat;
        model_code(v, cx, cy, ms, exp, exp_oof);
        cs = 17 + 4*v;
        exp_lat = 1 + NS*cs*cs + RL + 1;
        apply_start(v, cx, cy, ms);
        check({tag, "_busy"}, busy, 1);
        lat = 0;
        for (int k = 1; k <= exp_lat + 20; k++) begin
            if (valid_qr) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_size"}, code_size, cs);
        check({tag, "_bits"}, $countones(qr_code ^ exp), 0);
        check({tag, "_oof"},  error_oof, exp_oof);
        check({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, "_hold"}, $countones(qr_code ^ exp), 0);
        check({tag, "_vpulse"}, valid_qr, 0);
    endtask

    initial begin
        int vc;
        int low_bits;
        rst_n = 1'b0;
        start_in = 1'b0;
        version_in = '0;
        module_size = '0;
        centers_x = '0;
        centers_y = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Single lit pixel at the anchor module.
        for (int i = 0; i < W*H; i++) img[i] = 1'b0;
        img[112 + 112*W] = 1'b1;
`ifdef QR_SAMPLER_MAJORITY_EN
        img[113 + 112*W] = 1'b1;   // module (0,0): 2 of 3 set
        img[107 + 112*W] = 1'b1;   // module (1,0): 1 of 3 set
`endif
        run_req(1, 100, 100, 4, "point");
        check("point_b440", qr_code[440], 1);
        check("point_b439", qr_code[439], 0);
        check("point_ones", $countones(qr_code), 1);

        // Checkerboard, version 2.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[x + y*W] = bit'((x + y) & 1);
        run_req(2, 150, 120, 5, "chk");
        check("chk_high_zero", $countones(qr_code >> 625), 0);

        // Anchor near the frame corner: most modules fall outside.
        for (int i = 0; i < W*H; i++) img[i] = 1'b1;
        run_req(1, 10, 10, 8, "oof");
        check("oof_flag", error_oof, 1);
        low_bits = 0;
        for (int i = 0; i < 16*21; i++) low_bits += int'(qr_code[i]);
        check("oof_neg_py_bits", low_bits, 0);
        check("addr_in_range", addr_bad, 0);

        // Illegal versions: reject, then accept a start two cycles later.
        for (int t = 0; t < 2; t++) begin
            vc = valid_cnt;
            apply_start((t == 0) ? 0 : MAXV + 1, 100, 100, 4);
            check("badver_flag", error_ver, 1);
            check("badver_busy", busy, 0);
            @(negedge clk);
            version_in  = 3'd1;
            module_size = 9'd4;
            start_in    = 1'b1;
            @(negedge clk);
            start_in    = 1'b0;
            check("badver_reaccept", busy, 1);
            check("badver_clear", error_ver, 0);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            check("badver_novalid", valid_cnt, vc);
        end

        // Start while busy is ignored; reset mid-frame aborts the request.
        vc = valid_cnt;
        apply_start(1, 100, 100, 4);          // now in cycle 1
        repeat (49) @(negedge clk);           // cycle 50
        version_in = 3'd2;
        start_in   = 1'b1;
        @(negedge clk);
        start_in   = 1'b0;
        check("busy_start_size", code_size, 21);
        check("busy_start_busy", busy, 1);
        repeat (NS*200 + 1 - 51) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        rst_n = 1'b1;
        repeat (NS*500) @(negedge clk);
        check("abort_novalid", valid_cnt, vc);
        check("abort_size", code_size, 0);

        // Randomized requests over random images.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < W*H; i++) img[i] = bit'($urandom & 1);
            run_req(int'($urandom_range(1, MAXV)), int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 400)), int'($urandom_range(1, 12)), "rand");
        end
        check("addr_in_range_all", addr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
